// File: rtl/slot_loader.sv
// slot_loader: debounced pushbutton loader for four 2-bit slots.
// KEY[1] (active low) is synchronized and debounced by a five-state FSM;
// each validated press performs one write, either to the slot addressed
// by SW[9:8] (direct mode) or to the slot at the append pointer.
// SW[6] is a synchronized clear of all slots, pointer and full flag.
// Optional feature macro: SLOT_READBACK_EN (registered readback on rd_data).
module slot_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [9:0] SW,
  input  logic [3:0] KEY,
  output logic [9:0] LEDR,
  output logic       full,
  output logic [1:0] rd_data
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_WRITE   = 3'd2,
    ST_HELD    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  logic             key_s1_r;
  logic             key_s2_r;
  logic             clr_s1_r;
  logic             clr_s2_r;
  logic [1:0]       vld_r;
  logic             armed_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             cnt_done_s;
  logic             cnt_clr_s;
  logic             cnt_inc_s;
  logic             write_en_s;
  logic [1:0]       slot_r [4];
  logic [1:0]       ptr_r;
  logic             full_r;
  logic             unused_s;

  // Inputs that carry no function in this block.
  assign unused_s = ^{SW[5:2], KEY[3:2], KEY[0]};

  // Two-flop synchronizers; vld_r tracks when they hold real samples again after reset.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      key_s1_r <= 1'b1;
      key_s2_r <= 1'b1;
      clr_s1_r <= 1'b0;
      clr_s2_r <= 1'b0;
      vld_r    <= 2'b00;
    end else begin
      key_s1_r <= KEY[1];
      key_s2_r <= key_s1_r;
      clr_s1_r <= SW[6];
      clr_s2_r <= clr_s1_r;
      vld_r    <= {vld_r[0], 1'b1};
    end
  end

  // A key held through reset must be seen released before a press can be validated.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      armed_r <= 1'b0;
    end else if (vld_r[1] && key_s2_r) begin
      armed_r <= 1'b1;
    end else begin
      armed_r <= armed_r;
    end
  end

  assign cnt_nxt_s  = cnt_r + CNT_W'(1'b1);
  assign cnt_done_s = (CNT_LAST == CNT_W'(1'b0)) || (cnt_nxt_s == CNT_LAST);

  // FSM state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic; clear never influences the sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!key_s2_r && armed_r) state_nxt_s = ST_ARM;
        else                      state_nxt_s = ST_IDLE;
      end
      ST_ARM: begin
        if (key_s2_r)        state_nxt_s = ST_IDLE;
        else if (cnt_done_s) state_nxt_s = ST_WRITE;
        else                 state_nxt_s = ST_ARM;
      end
      ST_WRITE: begin
        state_nxt_s = ST_HELD;
      end
      ST_HELD: begin
        if (key_s2_r) state_nxt_s = ST_RELEASE;
        else          state_nxt_s = ST_HELD;
      end
      ST_RELEASE: begin
        if (!key_s2_r)       state_nxt_s = ST_HELD;
        else if (cnt_done_s) state_nxt_s = ST_IDLE;
        else                 state_nxt_s = ST_RELEASE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: counter control and the single-cycle write strobe.
  always_comb begin
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    write_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!key_s2_r && armed_r) cnt_clr_s = 1'b1;
        else                      cnt_clr_s = 1'b0;
      end
      ST_ARM: begin
        if (key_s2_r) cnt_inc_s = 1'b0;
        else          cnt_inc_s = 1'b1;
      end
      ST_WRITE: begin
        write_en_s = 1'b1;
      end
      ST_HELD: begin
        if (key_s2_r) cnt_clr_s = 1'b1;
        else          cnt_clr_s = 1'b0;
      end
      ST_RELEASE: begin
        if (key_s2_r) cnt_inc_s = 1'b1;
        else          cnt_inc_s = 1'b0;
      end
      default: begin
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        write_en_s = 1'b0;
      end
    endcase
  end

  // Debounce counter shared by the press and release qualification phases.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_inc_s) begin
      cnt_r <= cnt_nxt_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Slot storage, append pointer and full flag; clear beats a coincident write.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) slot_r[i] <= 2'b00;
      ptr_r  <= 2'b00;
      full_r <= 1'b0;
    end else if (clr_s2_r) begin
      for (int i = 0; i < 4; i++) slot_r[i] <= 2'b00;
      ptr_r  <= 2'b00;
      full_r <= 1'b0;
    end else if (write_en_s) begin
      if (!SW[7]) begin
        slot_r[SW[9:8]] <= SW[1:0];
      end else if (!full_r) begin
        slot_r[ptr_r] <= SW[1:0];
        ptr_r         <= ptr_r + 2'd1;
        if (ptr_r == 2'd3) full_r <= 1'b1;
      end
    end
  end

  assign LEDR = {ptr_r, slot_r[3], slot_r[0], slot_r[1], slot_r[2]};
  assign full = full_r;

`ifdef SLOT_READBACK_EN
  // Registered readback of the slot selected by SW[9:8].
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      rd_data <= 2'b00;
    end else begin
      rd_data <= slot_r[SW[9:8]];
    end
  end
`else
  assign rd_data = 2'b00;
`endif

endmodule

// File: tb/tb_slot_loader.sv
// Directed self-checking bench for slot_loader with DEBOUNCE_CYCLES = 4.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_slot_loader;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic       full;
  logic [1:0] rd_data;

  int n_assert = 0;
  int n_fail   = 0;

  slot_loader #(.DEBOUNCE_CYCLES(4)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .SW       (SW),
    .KEY      (KEY),
    .LEDR     (LEDR),
    .full     (full),
    .rd_data  (rd_data)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] mk_sw(input logic [1:0] addr, input logic mode,
                                       input logic clr, input logic [1:0] data);
    return {addr, mode, clr, 4'b0000, data};
  endfunction

  // One full press: LEDR must be unchanged 6 cycles after KEY low and updated at 7.
  task automatic press(input string tag, input logic [9:0] sw,
                       input logic [9:0] led_before, input logic [9:0] led_after);
    SW  = sw;
    KEY = 4'b1101;
    cyc(6);
    chk({tag, "_pre"}, LEDR, led_before);
    cyc(1);
    chk(tag, LEDR, led_after);
    cyc(3);
    KEY = 4'b1111;
    cyc(10);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    SW    = 10'b0000000000;
    KEY   = 4'b1111;
    cyc(2);
    chk("reset_ledr", LEDR, 10'h000);
    chk("reset_full", {9'b0, full}, 10'h000);
    chk("reset_rd",   {8'b0, rd_data}, 10'h000);
    reset = 1'b0;
    cyc(5);

    // Direct write to slot3
    press("direct_s3", mk_sw(2'b11, 1'b0, 1'b0, 2'b10), 10'h000, 10'h080);
    chk("direct_full", {9'b0, full}, 10'h000);

    // Bounce: low 2, high 1, low 2, then high -> no write
    SW  = mk_sw(2'b00, 1'b0, 1'b0, 2'b01);
    KEY = 4'b1101; cyc(2);
    KEY = 4'b1111; cyc(1);
    KEY = 4'b1101; cyc(2);
    KEY = 4'b1111; cyc(10);
    chk("bounce_nowrite", LEDR, 10'h080);

    // FSM back in IDLE: a clean press writes with the full latency
    press("direct_s0", mk_sw(2'b00, 1'b0, 1'b0, 2'b01), 10'h080, 10'h090);

    // Append fill
    press("app0", mk_sw(2'b00, 1'b1, 1'b0, 2'b01), 10'h090, 10'h190);
    press("app1", mk_sw(2'b00, 1'b1, 1'b0, 2'b10), 10'h190, 10'h298);
    press("app2", mk_sw(2'b00, 1'b1, 1'b0, 2'b11), 10'h298, 10'h39B);
    press("app3", mk_sw(2'b00, 1'b1, 1'b0, 2'b00), 10'h39B, 10'h01B);
    chk("app_full", {9'b0, full}, 10'h001);

    // Fifth append is dropped
    press("app_drop", mk_sw(2'b00, 1'b1, 1'b0, 2'b11), 10'h01B, 10'h01B);
    chk("app_drop_full", {9'b0, full}, 10'h001);

    // Readback of slot1 (holds 2'b10)
    SW = mk_sw(2'b01, 1'b1, 1'b0, 2'b11);
    cyc(1);
`ifdef SLOT_READBACK_EN
    chk("rd_slot1", {8'b0, rd_data}, 10'h002);
`else
    chk("rd_off", {8'b0, rd_data}, 10'h000);
`endif

    // Clear whose synchronized value is high in the WRITE cycle
    SW  = mk_sw(2'b10, 1'b0, 1'b0, 2'b11);
    KEY = 4'b1101;
    cyc(4);
    SW  = mk_sw(2'b10, 1'b0, 1'b1, 2'b11);
    cyc(3);
    chk("clr_write", LEDR, 10'h000);
    chk("clr_full", {9'b0, full}, 10'h000);
    SW  = mk_sw(2'b10, 1'b0, 1'b0, 2'b11);
    cyc(6);
    chk("clr_held", LEDR, 10'h000);
    KEY = 4'b1111;
    cyc(10);
    press("after_clr", mk_sw(2'b10, 1'b0, 1'b0, 2'b11), 10'h000, 10'h003);

    // Reset during ARM with the key held low
    SW  = mk_sw(2'b01, 1'b0, 1'b0, 2'b01);
    KEY = 4'b1101;
    cyc(4);
    reset = 1'b1;
    cyc(1);
    chk("rst_arm_ledr", LEDR, 10'h000);
    chk("rst_arm_rd", {8'b0, rd_data}, 10'h000);
    reset = 1'b0;
    cyc(12);
    chk("rst_held_nowrite", LEDR, 10'h000);
    KEY = 4'b1111;
    cyc(10);

    // New press after release writes slot1; readback trails LEDR by one cycle
    KEY = 4'b1101;
    cyc(6);
    chk("rst_press_pre", LEDR, 10'h000);
    cyc(1);
    chk("rst_press", LEDR, 10'h004);
`ifdef SLOT_READBACK_EN
    chk("rd_lag_old", {8'b0, rd_data}, 10'h000);
    cyc(1);
    chk("rd_lag_new", {8'b0, rd_data}, 10'h001);
`else
    cyc(1);
    chk("rd_off_end", {8'b0, rd_data}, 10'h000);
`endif
    KEY = 4'b1111;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/slot_loader.md
SLOT_LOADER -- requirements
Module: slot_loader

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: the number of consecutive stable synchronized samples that validates a press or a release.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port SW, input, 10 bits, with these fields:
- SW[1:0]: data.
- SW[6]: clear.
- SW[7]: mode (0 = direct, 1 = append).
- SW[9:8]: direct-mode slot address and readback select.
- SW[5:2]: unused.
REQ-005 SHALL have port KEY, input, 4 bits: KEY[1] is the active-low write pushbutton; KEY[0], KEY[2] and KEY[3] are unused.
REQ-006 SHALL have port LEDR, output, 10 bits, with these fields:
- LEDR[5:4]: slot0.
- LEDR[3:2]: slot1.
- LEDR[1:0]: slot2.
- LEDR[7:6]: slot3.
- LEDR[9:8]: append pointer.
REQ-007 SHALL have port full, output, 1 bit: high when append mode has filled all four slots.
REQ-008 SHALL have port rd_data, output, 2 bits: registered readback of the slot selected by SW[9:8].

Function
REQ-009 SHALL synchronize KEY[1] and SW[6] through two flip-flops each before use.
REQ-010 SHALL implement a debounce FSM with states IDLE, ARM, WRITE, HELD and RELEASE.
REQ-011 IDLE: go to ARM when synchronized KEY[1] = 0, clearing the counter.
REQ-012 ARM: return to IDLE if KEY[1] = 1; otherwise increment the counter, and go to WRITE when the counter reaches DEBOUNCE_CYCLES-1.
REQ-013 WRITE: last exactly one cycle, perform the write, then go to HELD.
REQ-014 HELD: stay in HELD while KEY[1] = 0; go to RELEASE when KEY[1] = 1, clearing the counter.
REQ-015 RELEASE: return to HELD if KEY[1] = 0; go to IDLE when the counter reaches DEBOUNCE_CYCLES-1.
REQ-016 SHALL perform exactly one write per validated press, regardless of how long the key is held.
REQ-017 SHALL sample SW[9:7] and SW[1:0] unsynchronized, in the WRITE cycle.
REQ-018 Direct mode: slot[SW[9:8]] <= SW[1:0]; the pointer and full are unchanged.
REQ-019 Append mode with full = 0: slot[ptr] <= SW[1:0], and ptr increments modulo 4.
REQ-020 Append mode, write to slot3: ptr wraps to 0 and full is set to 1.
REQ-021 Append mode with full = 1: the write SHALL be dropped; slots and ptr are unchanged, and the FSM still proceeds to HELD.
REQ-022 Clear: when synchronized SW[6] = 1, in any state, all slots, ptr and full SHALL go to 0 on the next edge.
REQ-023 Clear SHALL have priority over a coincident WRITE, whose write is dropped; clear SHALL NOT alter the FSM state.
REQ-024 SHALL show slot updates on LEDR one cycle after the WRITE cycle.
REQ-025 SHALL have a total latency of 2 + DEBOUNCE_CYCLES + 1 cycles from a KEY[1] low edge to the LEDR update.
REQ-026 SHALL drive LEDR, full and rd_data directly from registers.

Reset
REQ-027 SHALL, while reset = 1, asynchronously set slots = 0, ptr = 0, full = 0, rd_data = 0, FSM = IDLE and counter = 0.
REQ-028 SHALL, while reset = 1, asynchronously set the KEY[1] synchronizer flops to 1 (released) and the SW[6] synchronizer flops to 0.
REQ-029 A reset asserted mid-press SHALL abandon the press; after release, no write occurs until a new validated press.

Configuration
REQ-030 Macro SLOT_READBACK_EN SHALL control readback.
REQ-031 With SLOT_READBACK_EN defined: rd_data <= slot[SW[9:8]] each cycle, giving one-cycle latency; it reflects post-write contents one cycle after LEDR does.
REQ-032 With SLOT_READBACK_EN undefined: rd_data SHALL be held at 0, with no readback logic present; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES = 4)
REQ-033 Direct write: SW[7]=0, SW[9:8]=2'b11, SW[1:0]=2'b10, press KEY[1] 10 cycles -> LEDR[7:6]=2'b10 exactly 7 cycles after KEY low; ptr=0; full=0.
REQ-034 Bounce: KEY[1] low 2 cycles, high 1, low 2, then high -> no write; LEDR unchanged; FSM returns to IDLE.
REQ-035 Append fill: SW[7]=1, four presses with data 01, 10, 11, 00 -> LEDR[5:4]=01, [3:2]=10, [1:0]=11, [7:6]=00; ptr=0; full=1.
REQ-036 Fifth append press with data 11 -> slots unchanged; full=1.
REQ-037 Clear during WRITE: SW[6]=1 timed so its synchronized value is high in the WRITE cycle -> all slots 0, ptr 0, full 0; the key then requires release before the next write.
REQ-038 Reset mid-ARM, plus readback: reset pulse during ARM with KEY held low -> no write after reset deasserts, until KEY is released and pressed again.
REQ-039 With SLOT_READBACK_EN defined: SW[9:8]=2'b01 -> rd_data equals LEDR[3:2] one cycle later.
